dmem_lsu: RTL and testbench

- Load/store unit that acts as the CPU-side initiator for the single-port-per-direction word data memory `dmem` (ports: r_addr, w_addr, read, write, data_in, data_out).
- Accepts byte-addressed RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Converts each request to word-indexed dmem accesses, with sign/zero extension on loads.
- dmem has no byte enables, so SB/SH are done as read-modify-write. Returns one response pulse per request.

---
 rtl/lsu_pkg.sv | 9 +
 rtl/lsu_align.sv | 29 ++
 rtl/dmem_lsu.sv | 90 +++++++++
 tb/tb_dmem_lsu.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: RV32I load/store funct3 encodings and the LSU state type.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: lane select/extension of a read word for loads and byte/half merge for sub-word stores.
// Ports: word (read word), offset (byte offset), funct3, wdata (store data) -> load (extended value), merged (store word).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] load,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] mask;
  always_comb begin
    sh     = {offset, 3'b000};
    b      = 8'(word >> sh);
    h      = offset[1] ? word[31:16] : word[15:0];
    load   = funct3 == F3_B  ? {{24{b[7]}}, b} :
             funct3 == F3_BU ? {24'b0, b} :
             funct3 == F3_H  ? {{16{h[15]}}, h} :
             funct3 == F3_HU ? {16'b0, h} : word;
    // an aligned half has offset 0 or 2, so shifting wdata by offset*8 lands it in the right lane
    mask   = funct3 == F3_H ? 32'hFFFF << {offset[1], 4'b0} : 32'hFF << sh;
    merged = (word & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed RV32I load/store unit driving a word-wide dmem without byte enables.
// Ports: req_* (request handshake/payload), resp_* (one-cycle response), mem_* (dmem read/write side).
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_r_addr,
  output logic [31:0] mem_w_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  state_t      state, nxt;
  logic [29:0] idx;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic        we;
  logic [31:0] wd, ld, st;
  logic        fire, bad;
  lsu_align u_align (
    .word(mem_data_out), .offset(off), .funct3(f3), .wdata(wd), .load(ld), .merged(st)
  );
  assign req_ready  = state == IDLE;
  assign resp_valid = state == RESP;
  assign mem_read   = state == RD;
  assign mem_write  = state == WR;
  assign mem_r_addr = {2'b00, idx};
  assign mem_w_addr = {2'b00, idx};
  assign fire       = req_valid && req_ready;
  always_comb begin
    bad = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
          (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0) ||
          (req_we ? req_funct3 > F3_W : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11)) ||
          {2'b00, req_addr[31:2]} >= 32'(MEM_WORDS);
    nxt = state == IDLE ? (fire ? (bad ? RESP : (req_we && req_funct3 == F3_W) ? WR : RD) : IDLE) :
          state == RD   ? CAP :
          state == CAP  ? (we ? WR : RESP) :
          state == WR   ? RESP : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      off         <= '0;
      f3          <= '0;
      we          <= 1'b0;
      wd          <= '0;
      mem_data_in <= '0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
    end else begin
      state <= nxt;
      if (fire) begin
        idx <= req_addr[31:2];
        off <= req_addr[1:0];
        f3  <= req_funct3;
        we  <= req_we;
        wd  <= req_wdata;
        if (bad) begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end else if (req_we && req_funct3 == F3_W) mem_data_in <= req_wdata;
      end
      if (state == CAP) begin
        if (we) mem_data_in <= st;
        else begin
          resp_rdata <= ld;
          resp_err   <= 1'b0;
        end
      end
      if (state == WR) begin
        resp_rdata <= '0;
        resp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: byte-level reference model plus per-cycle compare for dmem_lsu, directed then random traffic.
module tb_dmem_lsu;
  localparam int MW = 256;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_r_addr, mem_w_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out = '0;
  always #5 clk = ~clk;
  dmem_lsu #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );
  logic [31:0] dm [MW];
  logic [7:0]  rb [4*MW];
  int cyc = 0, wr_total = 0, rsp_total = 0;
  int total = 0, bad = 0, issued = 0, served = 0, nr = 0, nw = 0;
  int e_start = 0, e_cyc = 0, e_nr = 0, e_nw = 0;
  logic [31:0] e_rd = '0, e_ww = '0, e_idx = '0;
  logic        e_er = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) for (int i = 0; i < MW; i++) dm[i] <= $urandom;
    if (mem_write) begin
      dm[mem_w_addr[7:0]] <= mem_data_in;
      wr_total <= wr_total + 1;
    end
    if (mem_read) mem_data_out <= dm[mem_r_addr[7:0]];
    if (resp_valid) rsp_total <= rsp_total + 1;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask
  task automatic tick();
    bit pend;
    @(negedge clk);
    pend = issued != served;
    chk("rw_exclusive", 32'(mem_read && mem_write), 0);
    if (pend && cyc > e_start) begin
      chk("busy_ready", 32'(req_ready), 0);
      if (mem_read) begin
        chk("r_addr", mem_r_addr, e_idx);
        nr++;
      end
      if (mem_write) begin
        chk("w_addr", mem_w_addr, e_idx);
        chk("w_data", mem_data_in, e_ww);
        nw++;
      end
    end
    if (pend && cyc == e_cyc) begin
      chk("resp_valid", 32'(resp_valid), 1);
      chk("resp_rdata", resp_rdata, e_rd);
      chk("resp_err", 32'(resp_err), 32'(e_er));
      chk("num_reads", nr, e_nr);
      chk("num_writes", nw, e_nw);
      served++;
      nr = 0;
      nw = 0;
    end else chk("no_resp", 32'(resp_valid), 0);
    @(posedge clk);
    #2;
  endtask
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output int n, output int r, output int w,
                       output logic [31:0] ww);
    int sz;
    logic [31:0] v;
    bit legal;
    sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
    legal = we ? f3 < 3'd3 : f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    er = !legal || (a % sz != 0) || (a / 4 >= MW);
    rd = 0; ww = 0; r = 0; w = 0; n = 1;
    if (!er && !we) begin
      v = 0;
      for (int i = 0; i < sz; i++) v |= 32'(rb[int'(a) + i]) << (8 * i);
      if (f3 == 3'd0 && v[7]) v |= 32'hFFFFFF00;
      if (f3 == 3'd1 && v[15]) v |= 32'hFFFF0000;
      rd = v; n = 3; r = 1;
    end else if (!er) begin
      for (int i = 0; i < sz; i++) rb[int'(a) + i] = wd[8*i +: 8];
      for (int i = 0; i < 4; i++) ww[8*i +: 8] = rb[int'(a & ~32'd3) + i];
      w = 1;
      r = sz < 4 ? 1 : 0;
      n = sz < 4 ? 4 : 2;
    end
  endtask
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input bit hold, input bit lit_en, input logic [31:0] lit);
    int g, n;
    g = 0;
    while (!req_ready && g < 20) begin
      tick();
      g++;
    end
    if (!req_ready) begin
      bad++;
      $display("FAIL ready_timeout: req_ready still 0 after %0d cycles", g);
      finish_run();
    end
    model(we, f3, a, wd, e_rd, e_er, n, e_nr, e_nw, e_ww);
    if (lit_en) chk("model_pin", we ? e_ww : e_rd, lit);
    e_idx = a >> 2;
    e_start = cyc;
    e_cyc = cyc + n;
    issued++;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    tick();
    if (!hold) req_valid = 1'b0;
    g = 0;
    while (issued != served && g < 20) begin
      tick();
      g++;
    end
    if (issued != served) begin
      bad++;
      $display("FAIL resp_timeout: no response after %0d cycles", g);
      finish_run();
    end
  endtask
  initial begin
    int w0, r0;
    bit we;
    logic [2:0] f3;
    logic [31:0] a;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", 32'(resp_err), 0);
    chk("rst_read", 32'(mem_read), 0);
    chk("rst_write", 32'(mem_write), 0);
    chk("rst_r_addr", mem_r_addr, 0);
    chk("rst_data_in", mem_data_in, 0);
    for (int i = 0; i < MW; i++) for (int j = 0; j < 4; j++) rb[4*i + j] = dm[i][8*j +: 8];
    rst = 1'b0;
    tick();
    issue(1, 3'd2, 32'h4, 32'h8899AABB, 0, 1, 32'h8899AABB);
    issue(0, 3'd0, 32'h5, 0, 0, 1, 32'hFFFFFFAA);
    issue(0, 3'd4, 32'h5, 0, 0, 1, 32'h000000AA);
    issue(0, 3'd5, 32'h6, 0, 0, 1, 32'h00008899);
    issue(0, 3'd1, 32'h6, 0, 0, 1, 32'hFFFF8899);
    issue(1, 3'd0, 32'h7, 32'h12345611, 0, 1, 32'h1199AABB);
    issue(0, 3'd2, 32'h4, 0, 0, 1, 32'h1199AABB);
    issue(1, 3'd1, 32'h4, 32'h0000BEEF, 0, 1, 32'h1199BEEF);
    issue(0, 3'd2, 32'h4, 0, 0, 1, 32'h1199BEEF);
    issue(0, 3'd2, 32'h6, 0, 0, 1, 0);
    issue(1, 3'd1, 32'h3, 32'hFFFF, 0, 1, 0);
    issue(0, 3'd3, 32'h0, 0, 0, 1, 0);
    issue(1, 3'd2, 32'(4 * MW), 32'h1, 0, 1, 0);
    // SB accepted, reset lands during CAP: no write, no response, word unchanged
    w0 = wr_total;
    r0 = rsp_total;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h7; req_wdata = 32'h55;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(req_ready), 1);
    chk("arst_read", 32'(mem_read), 0);
    chk("arst_write", 32'(mem_write), 0);
    chk("arst_w_addr", mem_w_addr, 0);
    chk("arst_resp", 32'(resp_valid), 0);
    @(posedge clk);
    #2;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("arst_no_write", wr_total - w0, 0);
    chk("arst_no_resp", rsp_total - r0, 0);
    issue(0, 3'd2, 32'h4, 0, 0, 1, 32'h1199BEEF);
    r0 = rsp_total;
    issue(0, 3'd2, 32'h4, 0, 1, 1, 32'h1199BEEF);
    issue(0, 3'd2, 32'h0, 0, 0, 0, 0);
    tick();
    chk("b2b_pulses", rsp_total - r0, 2);
    for (int k = 0; k < 300; k++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (we) f3 = 3'($urandom_range(0, 2));
        else begin
          f3 = 3'($urandom_range(0, 4));
          if (f3 == 3'd3) f3 = 3'd5;
        end
      end
      a = 32'($urandom_range(0, MW + 1)) * 4 + ($urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : 32'd0);
      if ($urandom_range(0, 31) == 0) a = $urandom;
      issue(we, f3, a, $urandom, 0, 0, 0);
    end
    finish_run();
  end
endmodule
